// File: rtl/l1_cache_monitor_pkg.sv
// l1_cache_monitor_pkg: shared constants and helpers for the L1 cache hit monitors
package l1_cache_monitor_pkg;
  localparam int DEF_WINDOW = 100;
  localparam int DEF_TOT_W  = 32;
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction
endpackage

// File: rtl/l1_cache_hit_window_channel.sv
// l1_cache_hit_window_channel: one channel's sliding-window hit count, fill, lifetime totals and alarm
module l1_cache_hit_window_channel
  import l1_cache_monitor_pkg::*;
#(
  parameter int P_WINDOW = DEF_WINDOW,
  parameter int P_CNT_W  = clog2(P_WINDOW + 1),
  parameter int P_TOT_W  = DEF_TOT_W
) (
  input  logic               iCLOCK,
  input  logic               inRESET,
  input  logic               clear_i,
  input  logic               valid_i,
  input  logic               hit_i,
  input  logic [P_CNT_W-1:0] threshold_i,
  output logic [P_CNT_W-1:0] count_o,
  output logic [P_CNT_W-1:0] fill_o,
  output logic               full_o,
  output logic [P_TOT_W-1:0] total_access_o,
  output logic [P_TOT_W-1:0] total_hit_o,
  output logic               alarm_o
);
  localparam logic [P_CNT_W-1:0] WIN = P_CNT_W'(P_WINDOW);
  logic [P_WINDOW-1:0] hist_q, hist_d;
  logic [P_CNT_W-1:0]  count_q, count_d, fill_q, fill_d;
  logic [P_TOT_W-1:0]  tacc_q, tacc_d, thit_q, thit_d;
  logic                alarm_q, alarm_d, full, evict;
  assign full  = fill_q == WIN;
  assign evict = hist_q[P_WINDOW-1];
  // Running sum stays exact: the evicted bit was counted when it entered the window.
  always_comb begin
    hist_d  = clear_i ? '0 : valid_i ? {hist_q[P_WINDOW-2:0], hit_i} : hist_q;
    count_d = clear_i ? '0 : valid_i ? count_q + P_CNT_W'(hit_i) - P_CNT_W'(evict) : count_q;
    fill_d  = clear_i ? '0 : (valid_i && !full) ? fill_q + P_CNT_W'(1) : fill_q;
    tacc_d  = clear_i ? '0 : (valid_i && !(&tacc_q)) ? tacc_q + P_TOT_W'(1) : tacc_q;
    thit_d  = clear_i ? '0 : (valid_i && hit_i && !(&thit_q)) ? thit_q + P_TOT_W'(1) : thit_q;
    alarm_d = !clear_i && full && (count_q < threshold_i);
  end
  always_ff @(posedge iCLOCK or negedge inRESET) begin
    if (!inRESET) begin
      hist_q  <= '0;
      count_q <= '0;
      fill_q  <= '0;
      tacc_q  <= '0;
      thit_q  <= '0;
      alarm_q <= 1'b0;
    end else begin
      hist_q  <= hist_d;
      count_q <= count_d;
      fill_q  <= fill_d;
      tacc_q  <= tacc_d;
      thit_q  <= thit_d;
      alarm_q <= alarm_d;
    end
  end
  assert property (@(posedge iCLOCK) disable iff (!inRESET) count_q == P_CNT_W'($countones(hist_q)));
  assign count_o        = count_q;
  assign fill_o         = fill_q;
  assign full_o         = full;
  assign total_access_o = tacc_q;
  assign total_hit_o    = thit_q;
  assign alarm_o        = alarm_q;
endmodule

// File: rtl/l1_cache_hit_window_monitor.sv
// l1_cache_hit_window_monitor: multi-channel sliding-window L1 cache hit monitor with packed outputs
module l1_cache_hit_window_monitor
  import l1_cache_monitor_pkg::*;
#(
  parameter int P_CHANNELS = 2,
  parameter int P_WINDOW   = DEF_WINDOW,
  parameter int P_CNT_W    = clog2(P_WINDOW + 1),
  parameter int P_TOT_W    = DEF_TOT_W
) (
  input  logic                          iCLOCK,
  input  logic                          inRESET,
  input  logic [P_CHANNELS-1:0]         iCLEAR,
  input  logic [P_CHANNELS-1:0]         iCACHE_VALID,
  input  logic [P_CHANNELS-1:0]         iCACHE_HIT,
  input  logic [P_CNT_W-1:0]            iTHRESHOLD,
  output logic [P_CHANNELS*P_CNT_W-1:0] oINFO_COUNT,
  output logic [P_CHANNELS*P_CNT_W-1:0] oINFO_FILL,
  output logic [P_CHANNELS-1:0]         oINFO_FULL,
  output logic [P_CHANNELS*P_TOT_W-1:0] oTOTAL_ACCESS,
  output logic [P_CHANNELS*P_TOT_W-1:0] oTOTAL_HIT,
  output logic [P_CHANNELS-1:0]         oALARM
);
  for (genvar c = 0; c < P_CHANNELS; c++) begin : g_ch
    l1_cache_hit_window_channel #(
      .P_WINDOW(P_WINDOW),
      .P_CNT_W (P_CNT_W),
      .P_TOT_W (P_TOT_W)
    ) u_ch (
      .iCLOCK        (iCLOCK),
      .inRESET       (inRESET),
      .clear_i       (iCLEAR[c]),
      .valid_i       (iCACHE_VALID[c]),
      .hit_i         (iCACHE_HIT[c]),
      .threshold_i   (iTHRESHOLD),
      .count_o       (oINFO_COUNT[c*P_CNT_W +: P_CNT_W]),
      .fill_o        (oINFO_FILL[c*P_CNT_W +: P_CNT_W]),
      .full_o        (oINFO_FULL[c]),
      .total_access_o(oTOTAL_ACCESS[c*P_TOT_W +: P_TOT_W]),
      .total_hit_o   (oTOTAL_HIT[c*P_TOT_W +: P_TOT_W]),
      .alarm_o       (oALARM[c])
    );
  end
endmodule

// File: tb/tb_l1_cache_hit_window_monitor.sv
// tb_l1_cache_hit_window_monitor: directed and random checks against a queue-based window model
module tb_l1_cache_hit_window_monitor;
  localparam int W = 100, CH = 2, CW = 7, TW = 32, SW = 4;
  logic iCLOCK = 1'b0, inRESET = 1'b0;
  logic [CH-1:0] clr = '0, vld = '0, hit = '0;
  logic [CW-1:0] thr = '0;
  logic [CH*CW-1:0] cnt, fil, s_cnt, s_fil;
  logic [CH-1:0] full, alarm, s_full, s_alarm;
  logic [CH*TW-1:0] tacc, thit;
  logic [CH*SW-1:0] s_tacc, s_thit;
  bit hq[CH][$];
  longint ta[CH], th[CH];
  bit al[CH];
  int checks = 0, passes = 0, fails = 0;

  l1_cache_hit_window_monitor dut (
    .iCLOCK(iCLOCK), .inRESET(inRESET), .iCLEAR(clr), .iCACHE_VALID(vld), .iCACHE_HIT(hit),
    .iTHRESHOLD(thr), .oINFO_COUNT(cnt), .oINFO_FILL(fil), .oINFO_FULL(full),
    .oTOTAL_ACCESS(tacc), .oTOTAL_HIT(thit), .oALARM(alarm));
  l1_cache_hit_window_monitor #(.P_TOT_W(SW)) dut_sat (
    .iCLOCK(iCLOCK), .inRESET(inRESET), .iCLEAR(clr), .iCACHE_VALID(vld), .iCACHE_HIT(hit),
    .iTHRESHOLD(thr), .oINFO_COUNT(s_cnt), .oINFO_FILL(s_fil), .oINFO_FULL(s_full),
    .oTOTAL_ACCESS(s_tacc), .oTOTAL_HIT(s_thit), .oALARM(s_alarm));

  initial forever #5 iCLOCK = ~iCLOCK;

  function automatic int pop(input int c);
    int n = 0;
    for (int i = 0; i < hq[c].size(); i++) n += int'(hq[c][i]);
    return n;
  endfunction

  function automatic longint sat(input longint v);
    return v > 15 ? 15 : v;
  endfunction

  task automatic chk(input string tag, input int c, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s ch%0d got=%0d exp=%0d", tag, c, got, exp);
    end
  endtask

  task automatic chk_all();
    for (int c = 0; c < CH; c++) begin
      chk("count", c, 64'(cnt[c*CW +: CW]), 64'(pop(c)));
      chk("fill", c, 64'(fil[c*CW +: CW]), 64'(hq[c].size()));
      chk("full", c, 64'(full[c]), 64'(hq[c].size() == W));
      chk("total_access", c, 64'(tacc[c*TW +: TW]), 64'(ta[c]));
      chk("total_hit", c, 64'(thit[c*TW +: TW]), 64'(th[c]));
      chk("alarm", c, 64'(alarm[c]), 64'(al[c]));
      chk("sat_total_access", c, 64'(s_tacc[c*SW +: SW]), 64'(sat(ta[c])));
      chk("sat_total_hit", c, 64'(s_thit[c*SW +: SW]), 64'(sat(th[c])));
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < CH; c++) begin
      hq[c].delete();
      ta[c] = 0;
      th[c] = 0;
      al[c] = 0;
    end
  endtask

  task automatic cyc(input logic [CH-1:0] c_, input logic [CH-1:0] v_, input logic [CH-1:0] h_);
    clr = c_;
    vld = v_;
    hit = h_;
    @(posedge iCLOCK);
    for (int c = 0; c < CH; c++) begin
      bit a;
      a = !c_[c] && hq[c].size() == W && pop(c) < int'(thr);
      if (c_[c]) begin
        hq[c].delete();
        ta[c] = 0;
        th[c] = 0;
      end else if (v_[c]) begin
        hq[c].push_back(h_[c]);
        if (hq[c].size() > W) void'(hq[c].pop_front());
        ta[c]++;
        if (h_[c]) th[c]++;
      end
      al[c] = a;
    end
    #1;
    chk_all();
  endtask

  initial begin
    logic [CH-1:0] rc, rv, rh;
    model_reset();
    repeat (2) @(posedge iCLOCK);
    #1;
    chk_all();
    inRESET = 1'b1;
    repeat (100) cyc(2'b00, 2'b01, 2'b01);
    chk("fill100", 0, 64'(fil[CW-1:0]), 64'd100);
    chk("count100", 0, 64'(cnt[CW-1:0]), 64'd100);
    chk("ch1_idle", 1, 64'(cnt[2*CW-1:CW]), 64'd0);
    thr = 7'd80;
    for (int i = 0; i < 30; i++) begin
      cyc(2'b00, 2'b01, 2'b00);
      if (i == 20) chk("alarm_at79", 0, 64'({cnt[CW-1:0], alarm[0]}), 64'({7'd79, 1'b0}));
      if (i == 21) chk("alarm_after79", 0, 64'(alarm[0]), 64'd1);
    end
    chk("count70", 0, 64'(cnt[CW-1:0]), 64'd70);
    thr = '0;
    for (int i = 0; i < 250; i++) begin
      rv = {1'($urandom_range(0, 1)), 1'b1};
      rh = {1'($urandom_range(0, 1)), 1'(i % 2 == 0)};
      cyc(2'b00, rv, rh);
    end
    chk("alt_count50", 0, 64'(cnt[CW-1:0]), 64'd50);
    cyc(2'b01, 2'b10, 2'b10);
    repeat (40) cyc(2'b00, 2'b11, 2'b11);
    cyc(2'b01, 2'b11, 2'b11);
    chk("clear_count", 0, 64'(cnt[CW-1:0]), 64'd0);
    chk("clear_tacc", 0, 64'(tacc[TW-1:0]), 64'd0);
    cyc(2'b01, 2'b11, 2'b11);
    cyc(2'b01, 2'b01, 2'b01);
    chk("clear_hold_fill", 0, 64'(fil[CW-1:0]), 64'd0);
    repeat (20) cyc(2'b00, 2'b01, 2'b01);
    chk("sat_acc15", 0, 64'(s_tacc[SW-1:0]), 64'd15);
    chk("sat_hit15", 0, 64'(s_thit[SW-1:0]), 64'd15);
    for (int i = 0; i < 400; i++) begin
      if (i % 50 == 0) thr = CW'($urandom_range(0, 100));
      rc = {1'($urandom_range(0, 63) == 0), 1'($urandom_range(0, 63) == 0)};
      rv = {1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) != 0)};
      rh = 2'($urandom_range(0, 3));
      cyc(rc, rv, rh);
    end
    clr = '0;
    vld = 2'b11;
    hit = 2'b11;
    #3 inRESET = 1'b0;
    #1;
    model_reset();
    chk_all();
    @(posedge iCLOCK);
    #1 inRESET = 1'b1;
    repeat (5) cyc(2'b00, 2'b01, 2'b01);
    chk("post_reset_count5", 0, 64'(cnt[CW-1:0]), 64'd5);
    chk("post_reset_fill5", 0, 64'(fil[CW-1:0]), 64'd5);
    chk("post_reset_full0", 0, 64'(full[0]), 64'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
